// File: rtl/prog_loader.sv
// Boot/program loader: parses a {header, base, data...} word stream and writes
// the images through the cpu's external IMEM/DMEM ports, then enables the cpu.
module prog_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        halt,
    output logic [31:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [31:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_RUN, S_ERR} state_e;

    localparam logic [32:0] IMEM_WORDS = 33'(IMEM_DEPTH);
    localparam logic [32:0] DMEM_WORDS = 33'(DMEM_DEPTH);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        target_q, target_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic [31:0] imem_addr_q, imem_addr_d, imem_wdata_q, imem_wdata_d;
    logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic        imem_wen_q, imem_wen_d, dmem_wen_q, dmem_wen_d;
    logic        cpu_enable_q, cpu_enable_d;
    logic [15:0] words_q, words_d;

    logic        xfer;
    logic [32:0] end_word;
    logic [32:0] target_words;

    assign s_ready      = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign xfer         = s_valid && s_ready;
    assign end_word     = {3'b000, s_data[31:2]} + {17'd0, remaining_q};
    assign target_words = target_q ? DMEM_WORDS : IMEM_WORDS;

    always_comb begin
        // NOTE: every variable gets its hold/idle value first so no path infers a latch.
        state_d      = state_q;
        last_d       = last_q;
        target_d     = target_q;
        remaining_d  = remaining_q;
        next_addr_d  = next_addr_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        imem_wen_d   = 1'b0;
        dmem_wen_d   = 1'b0;
        words_d      = words_q;
        cpu_enable_d = (state_q == S_RUN) && !halt;

        unique case (state_q)
            S_HDR: if (xfer) begin
                last_d      = s_data[31];
                target_d    = s_data[30];
                remaining_d = s_data[15:0];
                state_d     = (s_data[29:16] != 14'd0) ? S_ERR : S_ADDR;
            end
            S_ADDR: if (xfer) begin
                next_addr_d = s_data;
                if (s_data[1:0] != 2'b00 || end_word > target_words) state_d = S_ERR;
                else if (remaining_q == 16'd0) state_d = last_q ? S_RUN : S_HDR;
                else state_d = S_DATA;
            end
            S_DATA: if (xfer) begin
                if (target_q) begin
                    dmem_addr_d  = next_addr_q;
                    dmem_wdata_d = s_data;
                    dmem_wen_d   = 1'b1;
                end else begin
                    imem_addr_d  = next_addr_q;
                    imem_wdata_d = s_data;
                    imem_wen_d   = 1'b1;
                end
                next_addr_d = next_addr_q + 32'd4;
                remaining_d = remaining_q - 16'd1;
                if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
                if (remaining_q == 16'd1) state_d = last_q ? S_RUN : S_HDR;
            end
            S_RUN: if (halt) state_d = S_HDR;
            S_ERR: state_d = S_ERR;
            default: state_d = S_HDR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_HDR;
            last_q       <= 1'b0;
            target_q     <= 1'b0;
            remaining_q  <= 16'd0;
            next_addr_q  <= 32'd0;
            imem_addr_q  <= 32'd0;
            imem_wdata_q <= 32'd0;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
            imem_wen_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            cpu_enable_q <= 1'b0;
            words_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            target_q     <= target_d;
            remaining_q  <= remaining_d;
            next_addr_q  <= next_addr_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            imem_wen_q   <= imem_wen_d;
            dmem_wen_q   <= dmem_wen_d;
            cpu_enable_q <= cpu_enable_d;
            words_q      <= words_d;
        end
    end

    assign imem_addr    = imem_addr_q;
    assign imem_wen     = imem_wen_q;
    assign imem_wdata   = imem_wdata_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wen     = dmem_wen_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign cpu_enable   = cpu_enable_q;
    assign busy         = (state_q == S_ADDR) || (state_q == S_DATA);
    assign error        = (state_q == S_ERR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: segment-level model predicts writes,
// a negedge monitor checks every write pulse against the expected queue.
module tb_prog_loader;

    localparam int IMEM_DEPTH = 512;
    localparam int DMEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        halt = 1'b0;
    logic        s_ready;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic        imem_wen, dmem_wen, cpu_enable, busy, error;
    logic [15:0] words_loaded;

    prog_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .halt(halt), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .cpu_enable(cpu_enable), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          tgt;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  words_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (imem_wen || dmem_wen) begin
            check("wen_exclusive", {31'd0, imem_wen && dmem_wen}, 32'd0);
            check("no_enable_during_write", {31'd0, cpu_enable}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_target", {31'd0, dmem_wen}, {31'd0, e.tgt});
                check("write_addr", dmem_wen ? dmem_addr : imem_addr, e.addr);
                check("write_data", dmem_wen ? dmem_wdata : imem_wdata, e.data);
            end
        end
    end

    function automatic bit seg_err(input bit tgt, input logic [31:0] base, input int n);
        int depth;
        depth = tgt ? DMEM_DEPTH : IMEM_DEPTH;
        return (base % 4 != 0) || ((base / 4) + n > depth);
    endfunction

    task automatic send(input logic [31:0] w);
        int n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stuck at 0, word %h required to be accepted", w);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_segment(input bit last, input bit tgt, input logic [31:0] base,
                                input int n, input bit gap);
        logic [31:0] w;
        send({last, tgt, 14'd0, 16'(n)});
        check("busy_after_header", {31'd0, busy}, 32'd1);
        send(base);
        if (seg_err(tgt, base, n)) return;
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_q.push_back('{tgt: tgt, addr: base + 32'(4 * k), data: w});
            send(w);
            words_m++;
            if (gap && k < n - 1) idle();
        end
    endtask

    // Called right after the final transfer of a last segment.
    task automatic run_rise();
        s_valid = 1'b0;
        check("enable_low_first_cycle", {31'd0, cpu_enable}, 32'd0);
        check("ready_low_in_run", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        check("enable_rises", {31'd0, cpu_enable}, 32'd1);
        check("words_loaded", {16'd0, words_loaded}, 32'(words_m));
        @(negedge clk);
        check("enable_stays", {31'd0, cpu_enable}, 32'd1);
    endtask

    task automatic do_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("enable_drops_on_halt", {31'd0, cpu_enable}, 32'd0);
        check("ready_after_halt", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_imem_wen", {31'd0, imem_wen}, 32'd0);
        check("rst_dmem_wen", {31'd0, dmem_wen}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_ready", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        #2;
        arst_n = 1'b0;
        exp_q.delete();
        words_m = 0;
        #1;
        check_reset_values();
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_err_state(input string tag);
        s_valid = 1'b0;
        @(negedge clk);
        check({tag, "_error"}, {31'd0, error}, 32'd1);
        check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_enable"}, {31'd0, cpu_enable}, 32'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check({tag, "_sticky"}, {31'd0, error}, 32'd1);
    endtask

    initial begin
        #1;
        check_reset_values();
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Single IMEM last segment, back-to-back words, then halt and reload.
        load_segment(1'b1, 1'b0, 32'h0, 3, 1'b0);
        run_rise();
        do_halt();

        // DMEM segment followed by an IMEM last segment.
        load_segment(1'b0, 1'b1, 32'h10, 2, 1'b0);
        load_segment(1'b1, 1'b0, 32'h0, 1, 1'b0);
        run_rise();
        do_halt();

        // s_valid toggling between data words.
        load_segment(1'b1, 1'b0, 32'h100, 5, 1'b1);
        run_rise();
        do_halt();

        // Boundary segments that exactly fill the top of each memory, and N==0.
        load_segment(1'b0, 1'b1, 32'hFF0, 4, 1'b1);
        load_segment(1'b0, 1'b0, 32'h7FC, 1, 1'b0);
        load_segment(1'b1, 1'b1, 32'h40, 0, 1'b0);
        run_rise();
        do_halt();

        // Random multi-segment programs.
        for (int r = 0; r < 8; r++) begin
            int nseg;
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                bit tgt;
                int n, depth;
                tgt   = 1'($urandom_range(0, 1));
                depth = tgt ? DMEM_DEPTH : IMEM_DEPTH;
                n     = $urandom_range(0, 6);
                load_segment(s == nseg - 1, tgt, 32'(4 * $urandom_range(0, depth - n)), n,
                             1'($urandom_range(0, 1)));
            end
            run_rise();
            do_halt();
        end

        // Out-of-range, misaligned and reserved-bit errors.
        load_segment(1'b1, 1'b0, 32'h7FC, 2, 1'b0);
        check_err_state("range");
        do_reset();
        load_segment(1'b1, 1'b0, 32'h2, 1, 1'b0);
        check_err_state("align");
        do_reset();
        send(32'h8001_0001);
        check_err_state("reserved");
        do_reset();

        // Reset mid-segment abandons the image; a fresh segment then loads.
        send(32'h8000_0004);
        send(32'h20);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] w;
            w = $urandom;
            exp_q.push_back('{tgt: 1'b0, addr: 32'h20 + 32'(4 * k), data: w});
            send(w);
        end
        do_reset();
        load_segment(1'b1, 1'b0, 32'h0, 2, 1'b0);
        run_rise();

        repeat (3) @(negedge clk);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
